id_hazard_ctrl: RTL
===================

# id_hazard_ctrl

Hazard and flush controller for the five-stage pipelined MIPS core (IF, ID, EX, MEM, WB). It sits beside the registered instruction decoder and watches the opcode and register fields the decoder presents for the ID-stage instruction. It keeps its own shadow record of in-flight destination registers in EX, MEM and WB, and drives the PC, IF/ID and ID/EX pipeline-register controls. Its job is to stall on read-after-write hazards and to squash wrong-path instructions on a taken branch.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  rising-edge clock shared with the decoder
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID-stage instruction is real (0 = bubble)
- id_opcode  in  6  decoded Control field [31:26]
- id_rs  in  5  Read_Register_1 field [25:21]
- id_rt  in  5  Read_Register_2 field [20:16]
- id_rd  in  5  Write_Register field [15:11]
- branch_taken  in  1  branch resolved taken in EX this cycle
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID register load enable
- id_ex_bubble  out  1  load a NOP into ID/EX instead of the ID instruction
- flush_if_id  out  1  clear IF/ID to NOP
- stall  out  1  hazard stall active this cycle
- stall_cycles  out  CNT_W  saturating count of stalled cycles

## Operation
Register-use decode:
- opcode 0x00 (R-type): dest = rd; sources = rs, rt.
- Opcodes 0x23 (lw), 0x08, 0x0A, 0x0C, 0x0D: dest = rt; source = rs.
- Opcode 0x0F (lui): dest = rt; no sources.
- Opcodes 0x2B (sw), 0x04 (beq), 0x05 (bne): no dest; sources = rs, rt.
- Opcode 0x02 (j) and any other opcode: no dest, no sources.
- Register 0 is never a dest and never causes a hazard.

Shadow pipeline:
- Three slots, EX, MEM and WB. Each slot holds {valid, dest[4:0], is_load}.
- Every cycle the slots shift: WB←MEM, MEM←EX.
- EX takes the ID instruction's info unless any of these is true: stall, branch_taken, or id_valid=0. In those cases EX takes a bubble (valid=0).

Hazard condition (combinational, suppressed when id_valid=0):
- With FORWARDING_EN: EX slot valid, is_load=1, and its dest equals a used ID source.
- Without FORWARDING_EN: the EX or MEM slot is valid and its dest equals a used ID source.
- The WB slot never hazards, because the register file writes in the first half-cycle and reads in the second.

Control FSM, states RUN / STALL / FLUSH (the state is registered and reflects the previous cycle's cause):
- branch_taken=1: enter FLUSH. Outputs pc_write=1, if_id_write=1, flush_if_id=1, id_ex_bubble=1, stall=0. Flush takes priority over any hazard.
- Hazard present without a branch: enter STALL. Outputs pc_write=0, if_id_write=0, id_ex_bubble=1, stall=1.
- Otherwise: enter RUN. Outputs pc_write=1, if_id_write=1, id_ex_bubble=0, flush_if_id=0, stall=0.
- stall_cycles increments each cycle stall=1 and saturates at all-ones.

## Timing
- Hazard detection and control outputs are combinational from the ID inputs and the registered shadow slots. There are zero cycles of latency to the pipeline enables.
- Shadow slots, state and counter update on the rising clk edge.
- Stall length is re-evaluated every cycle and ends naturally as the producer drains out of the hazard window:
  - Load-use with FORWARDING_EN: 1 cycle.
  - Producer directly ahead, without FORWARDING_EN: 2 cycles.
  - Producer two ahead, without FORWARDING_EN: 1 cycle.
- branch_taken coincident with a hazard: flush behaviour only, and stall_cycles does not increment.
- While rst=1 (also when it is asserted mid-stall):
  - pc_write=0, if_id_write=0, id_ex_bubble=1, flush_if_id=1, stall=0.
  - All slots are invalid, state=RUN, stall_cycles=0.
- On the first cycle after rst deasserts, outputs are the RUN values.

## Configuration
- FORWARDING_EN defined: the datapath has EX/MEM→EX and MEM/WB→EX forwarding, so only load-use hazards stall.
- FORWARDING_EN undefined: every RAW hazard against EX or MEM stalls. is_load is still tracked but is not used.

## Structure
- Shared package mips_pkg holds:
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI.
  - The FSM state enum.
  - The shadow-slot struct type.
- One natural sub-module, mips_reg_use: purely combinational opcode-to-{dest, uses_rs, uses_rt, is_load} decode. It is reusable by the forwarding unit.

## Test plan
- lw $8,0($9), then add $10,$8,$11 in ID: with FORWARDING_EN, stall=1 for 1 cycle and pc_write=0 during it; without FORWARDING_EN, 2 cycles. stall_cycles ends at 1 or 2 respectively.
- add $8,$1,$2, then sub $3,$8,$4: with FORWARDING_EN, no stall; without, 2 stall cycles, then RUN.
- lw $0,0($1), then add $2,$0,$0: no stall in either configuration.
- sw $8,0($1) with lw $8 in EX: stall on the rt source. Same case with branch_taken=1: flush_if_id=1, id_ex_bubble=1, pc_write=1, stall=0.
- rst raised during the second stall cycle: reset values next edge; after release, an independent instruction flows with stall=0.
- id_valid=0 with matching fields: no stall, and the EX slot is loaded invalid.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, hazard FSM states, shadow-slot record.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Shadow pipeline slot indices
    localparam int SLOT_EX  = 0;
    localparam int SLOT_MEM = 1;
    localparam int SLOT_WB  = 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       is_load;
    } shadow_slot_t;

    // True when an in-flight producer writes a register the ID instruction reads.
    // $0 is hardwired, so it never matches.
    function automatic logic src_hit(input shadow_slot_t s,
                                     input logic uses_rs, input logic uses_rt,
                                     input logic [4:0] rs, input logic [4:0] rt);
        return s.valid && (s.dest != 5'd0) &&
               ((uses_rs && (rs == s.dest)) || (uses_rt && (rt == s.dest)));
    endfunction

endpackage

// File: rtl/mips_reg_use.sv
// Opcode decode to destination register, source usage and load flag.
// Latency: purely combinational.
// Backpressure: none.
import mips_pkg::*;

module mips_reg_use (
    input  logic [5:0] i_opcode,
    input  logic [4:0] i_rt,
    input  logic [4:0] i_rd,
    output logic [4:0] o_dest,
    output logic       o_dest_vld,
    output logic       o_uses_rs,
    output logic       o_uses_rt,
    output logic       o_is_load
);

    // Map each opcode class to which fields it writes and reads
    always_comb begin
        o_dest    = 5'd0;
        o_uses_rs = 1'b0;
        o_uses_rt = 1'b0;
        o_is_load = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_dest    = i_rd;
                o_uses_rs = 1'b1;
                o_uses_rt = 1'b1;
            end
            OP_LW: begin
                o_dest    = i_rt;
                o_uses_rs = 1'b1;
                o_is_load = 1'b1;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                o_dest    = i_rt;
                o_uses_rs = 1'b1;
            end
            OP_LUI: begin
                o_dest    = i_rt;
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                o_uses_rs = 1'b1;
                o_uses_rt = 1'b1;
            end
            default: begin
                o_dest    = 5'd0;
            end
        endcase
    end

    // A write to $0 is discarded, so it is not a destination at all
    assign o_dest_vld = (o_dest != 5'd0);

endmodule

// File: rtl/id_hazard_ctrl.sv
// RAW-stall and taken-branch flush controller for the ID stage (FORWARDING_EN: load-use only).
// Latency: enables are combinational from ID fields and registered shadow slots; state updates on clk.
// Backpressure: deasserts pc_write/if_id_write and bubbles ID/EX while a hazard persists.
import mips_pkg::*;

module id_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             flush_if_id,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cycles
);

    logic [4:0]       w_dest;
    logic             w_dest_vld;
    logic             w_uses_rs;
    logic             w_uses_rt;
    logic             w_is_load;
    logic             w_hazard;
    shadow_slot_t     w_id_slot;
    hz_state_e        w_state_nxt;
    hz_state_e        r_state;
    shadow_slot_t     r_slot [3];
    logic [CNT_W-1:0] r_stall_cnt;

    mips_reg_use u_reg_use (
        .i_opcode   (id_opcode),
        .i_rt       (id_rt),
        .i_rd       (id_rd),
        .o_dest     (w_dest),
        .o_dest_vld (w_dest_vld),
        .o_uses_rs  (w_uses_rs),
        .o_uses_rt  (w_uses_rt),
        .o_is_load  (w_is_load)
    );

    assign w_id_slot = '{valid: w_dest_vld, dest: w_dest, is_load: w_is_load};

    // RAW check of the ID sources against producers that cannot yet supply them.
    // WB is excluded: the register file writes first half-cycle, reads second.
    always_comb begin
        w_hazard = 1'b0;
`ifdef FORWARDING_EN
        w_hazard = id_valid && r_slot[SLOT_EX].is_load &&
                   src_hit(r_slot[SLOT_EX], w_uses_rs, w_uses_rt, id_rs, id_rt);
`else
        w_hazard = id_valid &&
                   (src_hit(r_slot[SLOT_EX],  w_uses_rs, w_uses_rt, id_rs, id_rt) ||
                    src_hit(r_slot[SLOT_MEM], w_uses_rs, w_uses_rt, id_rs, id_rt));
`endif
    end

    // Next-state and pipeline enables; flush outranks a stall, reset outranks both
    always_comb begin
        w_state_nxt  = r_state;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        flush_if_id  = 1'b0;
        stall        = 1'b0;
        if (rst) begin
            w_state_nxt  = ST_RUN;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            flush_if_id  = 1'b1;
        end else if (branch_taken) begin
            w_state_nxt  = ST_FLUSH;
            id_ex_bubble = 1'b1;
            flush_if_id  = 1'b1;
        end else if (w_hazard) begin
            w_state_nxt  = ST_STALL;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall        = 1'b1;
        end else begin
            w_state_nxt  = ST_RUN;
        end
    end

    // State register records the cause chosen this cycle
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    // Shadow pipeline: advance every cycle, EX gets a bubble when ID does not issue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot[SLOT_EX]  <= '0;
            r_slot[SLOT_MEM] <= '0;
            r_slot[SLOT_WB]  <= '0;
        end else begin
            r_slot[SLOT_WB]  <= r_slot[SLOT_MEM];
            r_slot[SLOT_MEM] <= r_slot[SLOT_EX];
            if (stall || branch_taken || !id_valid) r_slot[SLOT_EX] <= '0;
            else                                     r_slot[SLOT_EX] <= w_id_slot;
        end
    end

    // Saturating count of hazard-stalled cycles
    always_ff @(posedge clk) begin
        if (rst)                                    r_stall_cnt <= '0;
        else if (stall && (r_stall_cnt != '1))      r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign stall_cycles = r_stall_cnt;

endmodule
